// File: rtl/shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
// Rotate support follows PIPELINED_BARREL_SHIFTER_ROTATE_EN.
package shifter_pkg;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROT = 2'b11
    } shift_op_t;

    // Effective shift amount once out-of-range requests are folded.
    function automatic int unsigned amount_resolve(
        shift_op_t   op,
        int unsigned shift,
        int unsigned width
    );
        int unsigned amt;
        amt = shift;
        unique case (op)
            OP_SLL, OP_SRL: amt = (shift >= width) ? 0 : shift;
            OP_SRA:         amt = (shift >= width) ? width - 1 : shift;
            OP_ROT: begin
`ifdef PIPELINED_BARREL_SHIFTER_ROTATE_EN
                amt = shift % width;
`else
                amt = 0;
`endif
            end
        endcase
        return amt;
    endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_stage.sv
// One level of the log shifter: conditional shift by DIST, then register.
// Rotate wrap is built only with PIPELINED_BARREL_SHIFTER_ROTATE_EN.
module shifter_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    parameter int DIST  = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    input  shift_op_t                  in_op,
    input  logic                       in_fill,
    input  logic [$clog2(WIDTH)-1:0]   in_amt,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    output shift_op_t                  out_op,
    output logic                       out_fill,
    output logic [$clog2(WIDTH)-1:0]   out_amt,
    output logic [TAG_W-1:0]           out_tag
);

    localparam int SEL = $clog2(DIST);

    logic [WIDTH-1:0] shifted;

    // Shift by DIST when this level's amount bit is set.
    always_comb begin
        shifted = in_data;
        if (in_amt[SEL]) begin
            unique case (in_op)
                OP_SLL: shifted = in_data << DIST;
                OP_SRL, OP_SRA:
                    shifted = {{DIST{in_fill}}, in_data[WIDTH-1:DIST]};
                OP_ROT: begin
`ifdef PIPELINED_BARREL_SHIFTER_ROTATE_EN
                    shifted = {in_data[DIST-1:0], in_data[WIDTH-1:DIST]};
`else
                    shifted = in_data;
`endif
                end
            endcase
        end
    end

    // Stage register; holds everything when the pipe is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_op    <= OP_SLL;
            out_fill  <= 1'b0;
            out_amt   <= '0;
            out_tag   <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            out_data  <= shifted;
            out_op    <= in_op;
            out_fill  <= in_fill;
            out_amt   <= in_amt;
            out_tag   <= in_tag;
        end
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Fully pipelined logarithmic shifter with valid/ready and a sideband tag.
// Define PIPELINED_BARREL_SHIFTER_ROTATE_EN for rotate-right on op 11.
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    localparam int LOG2W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [LOG2W:0]     in_shift,
    input  logic [1:0]         in_op,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag
);

    logic               v    [LOG2W+1];
    logic [WIDTH-1:0]   d    [LOG2W+1];
    shift_op_t          op   [LOG2W+1];
    logic               fill [LOG2W+1];
    logic [LOG2W-1:0]   amt  [LOG2W+1];
    logic [TAG_W-1:0]   tag  [LOG2W+1];
    logic               advance;
    logic               unused_tail;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Resolve amount, operand and fill bit at accept.
    always_comb begin
        op[0]   = shift_op_t'(in_op);
        v[0]    = in_valid;
        tag[0]  = in_tag;
        amt[0]  = LOG2W'(amount_resolve(op[0], 32'(in_shift), WIDTH));
        fill[0] = (op[0] == OP_SRA) && in_data[WIDTH-1];
        d[0]    = in_data;
        if ((op[0] == OP_SLL || op[0] == OP_SRL) && in_shift[LOG2W])
            d[0] = '0;
    end

    for (genvar k = 0; k < LOG2W; k++) begin : g_stage
        shifter_stage #(
            .WIDTH (WIDTH),
            .TAG_W (TAG_W),
            .DIST  (1 << k)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .en        (advance),
            .in_valid  (v[k]),
            .in_data   (d[k]),
            .in_op     (op[k]),
            .in_fill   (fill[k]),
            .in_amt    (amt[k]),
            .in_tag    (tag[k]),
            .out_valid (v[k+1]),
            .out_data  (d[k+1]),
            .out_op    (op[k+1]),
            .out_fill  (fill[k+1]),
            .out_amt   (amt[k+1]),
            .out_tag   (tag[k+1])
        );
    end

    assign out_valid   = v[LOG2W];
    assign out_data    = d[LOG2W];
    assign out_tag     = tag[LOG2W];
    assign unused_tail = ^{op[LOG2W], fill[LOG2W], amt[LOG2W]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter (WIDTH 32).
// Expected results come from a plain-arithmetic shift model.
module tb_pipelined_barrel_shifter;

    localparam int W  = 32;
    localparam int TW = 4;
    localparam int LW = 5;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [W-1:0]  data;
    } res_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [LW:0]   in_shift;
    logic [1:0]    in_op;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [TW-1:0] out_tag;

    res_t exp_q[$];
    res_t obs_q[$];
    int   checks = 0;
    int   errors = 0;
    logic acc;

    pipelined_barrel_shifter #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shift  (in_shift),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(
        logic [1:0] op, logic [W-1:0] x, int unsigned s
    );
        int unsigned r;
        case (op)
            2'd0: return (s >= W) ? '0 : x << s;
            2'd1: return (s >= W) ? '0 : x >> s;
            2'd2: begin
                if (s >= W) return {W{x[W-1]}};
                return $signed(x) >>> s;
            end
            default: begin
`ifdef PIPELINED_BARREL_SHIFTER_ROTATE_EN
                r = s % W;
                if (r == 0) return x;
                return (x >> r) | (x << (W - r));
`else
                r = s;
                return x;
`endif
            end
        endcase
    endfunction

    // Advance one clock, logging accepted requests and consumed results.
    task automatic tick(output logic accepted);
        #1;
        accepted = in_valid && in_ready && !rst;
        if (out_valid && out_ready && !rst)
            obs_q.push_back({out_tag, out_data});
        if (accepted)
            exp_q.push_back({in_tag, model(in_op, in_data, in_shift)});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_shift = '0;
        in_op = '0;
        in_tag = '0;
        out_ready = 1'b1;
        repeat (3) tick(acc);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b want 0", out_valid);
        end
        checks++;
        if (out_data !== '0 || out_tag !== '0) begin
            errors++;
            $display("FAIL reset_data got %h/%h want 0/0", out_data, out_tag);
        end
        rst = 1'b0;
        tick(acc);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", in_ready);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_directed();
        logic [1:0]  ops  [11];
        logic [W-1:0] dat [11];
        int          sh   [11];
        logic [W-1:0] want[11];
        logic [W-1:0] rot_want;
`ifdef PIPELINED_BARREL_SHIFTER_ROTATE_EN
        rot_want = 32'h1000_000F;
`else
        rot_want = 32'h0000_00F1;
`endif
        ops = '{0, 2, 2, 1, 0, 1, 2, 3, 3, 0, 2};
        dat = '{32'h1, 32'h8000_0000, 32'h8000_0001, 32'hFFFF_FFFF,
                32'hA5C3_0F96, 32'hA5C3_0F96, 32'hA5C3_0F96,
                32'hA5C3_0F96, 32'hF1, 32'h1, 32'h7FFF_FFFF};
        sh  = '{31, 4, 63, 40, 0, 0, 0, 0, 36, 32, 40};
        want = '{32'h8000_0000, 32'hF800_0000, 32'hFFFF_FFFF, 32'h0,
                 32'hA5C3_0F96, 32'hA5C3_0F96, 32'hA5C3_0F96,
                 32'hA5C3_0F96, rot_want, 32'h0, 32'h0};
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            in_valid = 1'b1;
            in_op = ops[i];
            in_data = dat[i];
            in_shift = (LW+1)'(sh[i]);
            in_tag = TW'(i + 3);
            tick(acc);
            in_valid = 1'b0;
            checks++;
            if (acc !== 1'b1) begin
                errors++;
                $display("FAIL dir%0d_accept got %b want 1", i, acc);
            end
            repeat (LW - 2) tick(acc);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL dir%0d_early got %b want 0", i, out_valid);
            end
            tick(acc);
            checks++;
            if (out_valid !== 1'b1 || out_data !== want[i] ||
                out_tag !== TW'(i + 3)) begin
                errors++;
                $display("FAIL dir%0d_result got v%b %h/%h want v1 %h/%h",
                         i, out_valid, out_data, out_tag, want[i], TW'(i + 3));
            end
            tick(acc);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_back_to_back();
        int budget;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_op = 2'd0;
            in_data = 32'h1;
            in_shift = (LW+1)'(i);
            in_tag = TW'(i);
            tick(acc);
            checks++;
            if (acc !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready%0d got %b want 1", i, acc);
            end
        end
        in_valid = 1'b0;
        budget = 0;
        while (obs_q.size() < 8 && budget < 20) begin
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL b2b_gap got %b want 1 after %0d results",
                         out_valid, obs_q.size());
            end
            tick(acc);
            budget++;
        end
        checks++;
        if (obs_q.size() != 8) begin
            errors++;
            $display("FAIL b2b_count got %0d want 8", obs_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < 8; i++) begin
            checks++;
            if (obs_q[i] !== {TW'(i), 32'h1 << i}) begin
                errors++;
                $display("FAIL b2b_res%0d got %h want %h",
                         i, obs_q[i], {TW'(i), 32'h1 << i});
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_backpressure();
        int   sent;
        res_t held;
        sent = 0;
        for (int t = 0; t < 60; t++) begin
            if (sent == 6 && obs_q.size() >= 6) break;
            in_valid = (sent < 6);
            in_op = 2'($urandom_range(0, 3));
            in_data = $urandom;
            in_shift = (LW+1)'($urandom_range(0, 63));
            in_tag = TW'(sent + 8);
            out_ready = !(t >= 6 && t < 9);
            #1;
            if (t == 6) held = {out_tag, out_data};
            if (t >= 6 && t < 9) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_ready t%0d got %b want 0", t, in_ready);
                end
                checks++;
                if (out_valid !== 1'b1 || {out_tag, out_data} !== held) begin
                    errors++;
                    $display("FAIL bp_hold t%0d got v%b %h want v1 %h",
                             t, out_valid, {out_tag, out_data}, held);
                end
            end
            tick(acc);
            if (acc) sent++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (obs_q.size() != 6 || exp_q.size() != 6) begin
            errors++;
            $display("FAIL bp_count got %0d/%0d want 6/6",
                     obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bp_res%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_random();
        int budget;
        for (int t = 0; t < 300; t++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_op = 2'($urandom_range(0, 3));
            in_data = $urandom;
            in_shift = (LW+1)'($urandom_range(0, 63));
            in_tag = TW'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            tick(acc);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        budget = 0;
        while (obs_q.size() < exp_q.size() && budget < 50) begin
            tick(acc);
            budget++;
        end
        checks++;
        if (obs_q.size() != exp_q.size() || exp_q.size() == 0) begin
            errors++;
            $display("FAIL rnd_count got %0d want %0d",
                     obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rnd_res%0d got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_op = 2'd0;
            in_data = $urandom;
            in_shift = (LW+1)'(i);
            in_tag = TW'(i);
            tick(acc);
        end
        rst = 1'b1;
        tick(acc);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_state got v%b r%b want v0 r1",
                     out_valid, in_ready);
        end
        for (int i = 0; i < 10; i++) begin
            tick(acc);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_leak%0d got %b want 0", i, out_valid);
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL rstmid_obs got %0d want 0", obs_q.size());
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_barrel_shifter.md
# pipelined_barrel_shifter

Parametrised, fully pipelined logarithmic shifter for the datapath. It performs logical left, logical right and arithmetic right shifts, plus rotate-right when compiled in. It accepts one operation per cycle through a valid/ready handshake and carries a sideband tag so the issuing stage can match results to requests. It is the pipelined, width-generic successor to the single-cycle 32-bit case-table shifter. It sits between operand read and writeback in the ALU path.

## Interface
Parameters:
- WIDTH, 32: data width; must be a power of two, ≥ 4.
- TAG_W, 4: sideband tag width, passed through unchanged.
- LOG2W, $clog2(WIDTH): derived; number of shift levels, equal to the pipeline depth. Not overridable.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  request present.
- in_ready  out  1  request accepted this cycle when in_valid && in_ready.
- in_data  in  WIDTH  operand.
- in_shift  in  LOG2W+1  shift amount, unsigned; range 0..2·WIDTH−1.
- in_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR/pass (see Configuration).
- in_tag  in  TAG_W  sideband, returned with the result.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_data  out  WIDTH  result.
- out_tag  out  TAG_W  tag of that result.

## Operation
- There are LOG2W registered stages. Stage k (k = 0..LOG2W−1) conditionally shifts by 2^k using bit k of the effective amount. Each stage register holds valid, data, op, fill bit, amount and tag.
- Effective amount is resolved at accept:
  - SLL/SRL with in_shift ≥ WIDTH: operand forced to 0 and amount to 0.
  - SRA with in_shift ≥ WIDTH: amount saturates to WIDTH−1, so the result is all sign bits.
  - ROR: amount taken modulo WIDTH, i.e. bit LOG2W is ignored.
  - Otherwise the amount is in_shift[LOG2W−1:0].
- Fill rules:
  - SLL and SRL fill with 0.
  - SRA fills with in_data[WIDTH−1], captured at accept.
  - ROR wraps bits around.
- Shift amount 0 returns in_data unchanged for every op.
- Global stall: advance = !out_valid || out_ready.
  - All stages shift together only when advance is 1; otherwise every stage register holds.
  - in_ready = advance, combinational from out_ready and out_valid only.
  - Bubbles are not collapsed. A stage holding valid = 0 still occupies its slot.
- Results emerge strictly in acceptance order. No request is lost or duplicated under any pattern of out_ready.
- Reset: all stage valid bits and out_valid are 0; out_data and out_tag are 0. in_ready is 1 in the cycle after reset deasserts.
- Reset mid-operation: every in-flight request is discarded and nothing emerges afterwards. A request presented in the same cycle that rst is high is not accepted.

## Timing
- Latency is LOG2W cycles from the accepting edge to out_valid rising when out_ready stays high (5 cycles for WIDTH = 32).
- Throughput is one request per cycle with no bubble between back-to-back requests.
- out_data, out_tag and out_valid are driven directly from the last stage register. They hold stable while out_valid && !out_ready.
- Simultaneous accept and emit in the same cycle is normal operation; occupancy is unchanged.
- The combinational path per stage is one 2:1 mux plus fill logic. in_ready depends combinationally on out_ready (one gate).

## Configuration
- Macro name: PIPELINED_BARREL_SHIFTER_ROTATE_EN.
- Defined: op 11 is rotate-right by in_shift mod WIDTH.
- Undefined: op 11 is pass-through, with out_data = in_data after the same latency. Rotate wrap logic is not built.
- Handshake and latency are identical in both builds.

## Structure
- Shared package shifter_pkg holds:
  - shift_op_t, a 2-bit enum: OP_SLL = 2'b00, OP_SRL = 2'b01, OP_SRA = 2'b10, OP_ROT = 2'b11.
  - Function amount_resolve(op, shift, width), used at accept.
- Sub-module shifter_stage holds one level: parameters WIDTH, TAG_W, DIST; a 2:1 shift mux and the stage register with enable.
  - The top instantiates LOG2W copies in a generate loop with DIST = 2^k.
  - The top owns the accept logic, the advance/in_ready logic and reset.

## Test plan
WIDTH = 32, out_ready = 1 unless stated otherwise.
1. SLL: in_data 0x0000_0001, in_shift 31, tag 3 → after 5 cycles out_data 0x8000_0000, out_tag 3.
2. SRA: 0x8000_0000 shift 4 → 0xF800_0000. SRA 0x8000_0001 shift 63 → 0xFFFF_FFFF. SRL 0xFFFF_FFFF shift 40 → 0x0000_0000. Any op with shift 0 → input unchanged.
3. Back-to-back: 8 SLL requests on consecutive cycles, shift = i, data 0x1 → 8 consecutive outputs 0x1 << i in order; in_ready stays 1 throughout.
4. Backpressure: stream 6 requests, drop out_ready for 3 cycles mid-stream → in_ready low in those cycles, out_data/out_tag held stable, all 6 results delivered in order with none duplicated.
5. Op 11, 0x0000_00F1 shift 36 → 0x1000_000F with PIPELINED_BARREL_SHIFTER_ROTATE_EN defined; 0x0000_00F1 without it.
6. Accept 3 requests, assert rst one cycle while in_valid = 1 → out_valid 0 from the next cycle, no result emerges in the following 10 cycles, in_ready 1 after rst deasserts.
